// File: rtl/apb_master_bridge_if.sv
// Bundle of the local command/response port and the APB requester bus.
// The master modport is the bridge's view; the slave modport is the view
// of the environment that issues commands and plays the APB slave.
interface apb_master_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  // local command port
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  // local response port
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  // APB bus
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester bridge: single-beat valid/ready commands become APB
// SETUP/ACCESS transfers; completion, slave error and wait-state timeout
// are reported as a one-cycle response pulse.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic pclk,
  input  logic preset,
  apb_master_bridge_if.master bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t                state_q, state_d;
  logic                  psel_q, penable_q;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic timeout_hit;
  logic cmd_ready;
  logic accept;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == TO_VAL) && !bus.pready;
  assign cmd_ready   = !preset && ((state_q == ST_IDLE) ||
                       ((state_q == ST_ACCESS) && (bus.pready || timeout_hit)));
  assign accept      = bus.cmd_valid && cmd_ready;

  // Next-state, address/data latch, wait counter and response generation
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    wait_d        = wait_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = accept ? ST_SETUP : ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = accept ? ST_SETUP : ST_IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Both the IDLE and the back-to-back ACCESS accept paths latch here
    if (accept) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
    end
  end

  // State and registered bus/response outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= (state_d != ST_IDLE);
      penable_q     <= (state_d == ST_ACCESS);
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic preset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.pready = 1'b1;
    repeat (3) tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
    end
    n_checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    bus.pready = 1'b0;
    tick();
    preset = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    bus.pready = 1'b1;
    drive_cmd(1'b1, 32'h04, 32'hA5A5_0001);
    tick();  // accept edge
    bus.cmd_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid} !== 4'b1010 ||
        bus.paddr !== 32'h04 || bus.pwdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL wr_setup got=%b/%h/%h exp=1010/00000004/a5a50001",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}, bus.paddr, bus.pwdata);
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL wr_access got=%b exp=1101",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 5'b00100 ||
        bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rsp got=%b/%h exp=00100/00000000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
    n_checks++;
    if (bus.paddr !== 32'h04 || bus.pwdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL wr_idle_hold got=%h/%h exp=00000004/a5a50001", bus.paddr, bus.pwdata);
    end
    tick();
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp_pulse got=%b exp=0", bus.rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    bus.pready  = 1'b0;
    bus.prdata  = 32'hDEAD_BEEF;
    bus.pslverr = 1'b1;
    drive_cmd(1'b0, 32'h04, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100 || bus.paddr !== 32'h04) begin
      n_fail++;
      $display("FAIL rd_setup got=%b/%h exp=100/00000004", {bus.psel, bus.penable, bus.pwrite}, bus.paddr);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin
        bus.pready  = 1'b1;
        bus.prdata  = 32'hA5A5_0001;
        bus.pslverr = 1'b0;
      end
      #1;
      n_checks++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== {3'b110, (i == 3)} ||
          bus.paddr !== 32'h04) begin
        n_fail++;
        $display("FAIL rd_access_%0d got=%b/%h exp=110%0d/00000004", i,
                 {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, bus.paddr, (i == 3));
      end
    end
    tick();
    bus.pready = 1'b0;
    #1;
    n_checks++;
    if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0100 ||
        bus.rsp_rdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rd_rsp got=%b/%h exp=0100/a5a50001",
               {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bus.pready = 1'b1;
    drive_cmd(1'b1, 32'h08, 32'h0000_1111);
    tick();
    drive_cmd(1'b1, 32'h0C, 32'h0000_2222);
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b100 || bus.paddr !== 32'h08) begin
      n_fail++;
      $display("FAIL b2b_setup1 got=%b/%h exp=100/00000008", {bus.psel, bus.penable, bus.cmd_ready}, bus.paddr);
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b111 || bus.pwdata !== 32'h0000_1111) begin
      n_fail++;
      $display("FAIL b2b_access1 got=%b/%h exp=111/00001111", {bus.psel, bus.penable, bus.cmd_ready}, bus.pwdata);
    end
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b101 ||
        bus.paddr !== 32'h0C || bus.pwdata !== 32'h0000_2222) begin
      n_fail++;
      $display("FAIL b2b_setup2 got=%b/%h/%h exp=101/0000000c/00002222",
               {bus.psel, bus.penable, bus.rsp_valid}, bus.paddr, bus.pwdata);
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_access2 got=%b exp=110", {bus.psel, bus.penable, bus.rsp_valid});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_rsp2 got=%b exp=0010", {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err});
    end
  endtask

  task automatic test_timeout();
    bus.pready = 1'b0;
    bus.prdata = 32'hFFFF_FFFF;
    drive_cmd(1'b0, 32'h10, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      #1;
      n_checks++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== {3'b110, (i == 9)}) begin
        n_fail++;
        $display("FAIL to_access_%0d got=%b exp=110%0d", i,
                 {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, (i == 9));
      end
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 5'b00111 ||
        bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_rsp got=%b/%h exp=00111/00000000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
  endtask

  task automatic test_slverr();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h1234_5678;
    drive_cmd(1'b0, 32'h14, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110 || bus.rsp_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL slverr_rsp got=%b/%h exp=110/12345678",
               {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
    end
    bus.pslverr = 1'b0;
    bus.pready  = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.pready = 1'b0;
    drive_cmd(1'b0, 32'h18, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    preset = 1'b1;
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_pre got=%b exp=110", {bus.psel, bus.penable, bus.cmd_ready});
    end
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0 ||
        {bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%h exp=000000/0",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout},
               {bus.paddr, bus.pwdata, bus.rsp_rdata});
    end
    preset = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_after got=%b exp=001", {bus.psel, bus.rsp_valid, bus.cmd_ready});
    end
    bus.pready = 1'b1;
    drive_cmd(1'b1, 32'h1C, 32'h0000_005A);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b0100 ||
        bus.paddr !== 32'h1C || bus.pwdata !== 32'h0000_005A) begin
      n_fail++;
      $display("FAIL mid_new_cmd got=%b/%h/%h exp=0100/0000001c/0000005a",
               {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.paddr, bus.pwdata);
    end
  endtask

  initial begin
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
